// File: rtl/dcm_ps_ctrl.sv
// DCM reset/lock sequencer with a single-step dynamic phase-shift front end.
// Recovers from lock loss or stopped CLKIN by re-running the reset pulse.
`timescale 1ns/1ps
module dcm_ps_ctrl #(
  parameter int RST_CYCLES   = 3,
  parameter int LOCK_TIMEOUT = 4095,
  parameter int PS_RANGE     = 255
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              relock,
  input  logic              step_req,
  input  logic              step_inc,
  output logic              step_ack,
  output logic              step_rej,
  output logic              dcm_rst,
  input  logic              dcm_locked,
  input  logic [7:0]        dcm_status,
  output logic              dcm_psen,
  output logic              dcm_psincdec,
  input  logic              dcm_psdone,
  output logic              ready,
  output logic signed [8:0] phase,
  output logic              lock_err,
  output logic              ps_err
);

  localparam int SYNC_STAGES = 2;
  localparam int CNT_MAX     = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int CW          = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic signed [8:0] PMAX = 9'(PS_RANGE);
  localparam logic signed [8:0] PMIN = -PMAX;

  typedef enum logic [2:0] {
    RST_PULSE,
    WAIT_LOCK,
    IDLE,
    PS_ISSUE,
    PS_WAIT
  } state_t;

  state_t              state_reg;
  logic [CW-1:0]       cnt_reg;
  logic                lock_sync_reg [SYNC_STAGES];
  logic                step_ack_reg;
  logic                step_rej_reg;
  logic                dcm_rst_reg;
  logic                dcm_psen_reg;
  logic                dcm_psincdec_reg;
  logic                ready_reg;
  logic signed [8:0]   phase_reg;
  logic                lock_err_reg;
  logic                ps_err_reg;

  logic lock_ok;
  logic fault;
  logic at_limit;
  logic enter_rst;
  logic unused_status;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_lock_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge m_clock) begin
          if (p_reset) lock_sync_reg[gi] <= 1'b0;
          else         lock_sync_reg[gi] <= dcm_locked;
        end
      end else begin : g_next
        always_ff @(posedge m_clock) begin
          if (p_reset) lock_sync_reg[gi] <= 1'b0;
          else         lock_sync_reg[gi] <= lock_sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign lock_ok       = lock_sync_reg[SYNC_STAGES-1];
  assign fault         = !lock_ok || dcm_status[1];
  assign at_limit      = step_inc ? (phase_reg == PMAX) : (phase_reg == PMIN);
  assign unused_status = ^{dcm_status[7:2], dcm_status[0]};

  // Every path back to RST_PULSE funnels through here; lock loss beats PSDONE.
  always_comb begin
    enter_rst = 1'b0;
    case (state_reg)
      WAIT_LOCK: enter_rst = !lock_ok && (cnt_reg == TO_LAST);
      IDLE:      enter_rst = fault || relock;
      PS_ISSUE:  enter_rst = fault;
      PS_WAIT:   enter_rst = fault || (!dcm_psdone && (cnt_reg == TO_LAST));
      default:   enter_rst = 1'b0;
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_reg        <= RST_PULSE;
      cnt_reg          <= '0;
      step_ack_reg     <= 1'b0;
      step_rej_reg     <= 1'b0;
      dcm_rst_reg      <= 1'b1;
      dcm_psen_reg     <= 1'b0;
      dcm_psincdec_reg <= 1'b0;
      ready_reg        <= 1'b0;
      phase_reg        <= '0;
      lock_err_reg     <= 1'b0;
      ps_err_reg       <= 1'b0;
    end else begin
      step_ack_reg <= 1'b0;
      step_rej_reg <= 1'b0;
      dcm_psen_reg <= 1'b0;
      if (enter_rst) begin
        state_reg   <= RST_PULSE;
        cnt_reg     <= '0;
        dcm_rst_reg <= 1'b1;
        ready_reg   <= 1'b0;
        phase_reg   <= '0;
        if (state_reg == WAIT_LOCK) lock_err_reg <= 1'b1;
        if (state_reg == PS_WAIT && !fault) ps_err_reg <= 1'b1;
      end else begin
        case (state_reg)
          RST_PULSE: begin
            phase_reg <= '0;
            if (cnt_reg == RST_LAST) begin
              state_reg   <= WAIT_LOCK;
              dcm_rst_reg <= 1'b0;
              cnt_reg     <= '0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          WAIT_LOCK: begin
            if (lock_ok) begin
              state_reg <= IDLE;
              ready_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          IDLE: begin
            // The ack cycle blanks step_req so a held level yields one step per ack.
            if (step_req && !step_ack_reg) begin
              if (at_limit) begin
                step_ack_reg <= 1'b1;
                step_rej_reg <= 1'b1;
              end else begin
                state_reg        <= PS_ISSUE;
                dcm_psen_reg     <= 1'b1;
                dcm_psincdec_reg <= step_inc;
                ready_reg        <= 1'b0;
              end
            end
          end
          PS_ISSUE: begin
            state_reg <= PS_WAIT;
            cnt_reg   <= '0;
          end
          PS_WAIT: begin
            if (dcm_psdone) begin
              state_reg    <= IDLE;
              ready_reg    <= 1'b1;
              step_ack_reg <= 1'b1;
              phase_reg    <= dcm_psincdec_reg ? phase_reg + 9'sd1 : phase_reg - 9'sd1;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          default: begin
            state_reg   <= RST_PULSE;
            cnt_reg     <= '0;
            dcm_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign step_ack     = step_ack_reg;
  assign step_rej     = step_rej_reg;
  assign dcm_rst      = dcm_rst_reg;
  assign dcm_psen     = dcm_psen_reg;
  assign dcm_psincdec = dcm_psincdec_reg;
  assign ready        = ready_reg;
  assign phase        = phase_reg;
  assign lock_err     = lock_err_reg;
  assign ps_err       = ps_err_reg;

endmodule

// File: tb/tb_dcm_ps_ctrl.sv
// Directed bench for dcm_ps_ctrl: step vector table plus hand sequences for
// bring-up, timeouts, lock loss and relock handling.
`timescale 1ns/1ps
module tb_dcm_ps_ctrl;

  logic              m_clock = 1'b0;
  logic              p_reset;
  logic              relock;
  logic              step_req;
  logic              step_inc;
  logic              step_ack;
  logic              step_rej;
  logic              dcm_rst;
  logic              dcm_locked;
  logic [7:0]        dcm_status;
  logic              dcm_psen;
  logic              dcm_psincdec;
  logic              dcm_psdone;
  logic              ready;
  logic signed [8:0] phase;
  logic              lock_err;
  logic              ps_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit pre_relock;
    bit inc;
    int exp_phase;
    bit exp_rej;
  } vec_t;

  vec_t vecs [8];

  dcm_ps_ctrl #(
    .RST_CYCLES  (3),
    .LOCK_TIMEOUT(100),
    .PS_RANGE    (2)
  ) dut (
    .m_clock     (m_clock),
    .p_reset     (p_reset),
    .relock      (relock),
    .step_req    (step_req),
    .step_inc    (step_inc),
    .step_ack    (step_ack),
    .step_rej    (step_rej),
    .dcm_rst     (dcm_rst),
    .dcm_locked  (dcm_locked),
    .dcm_status  (dcm_status),
    .dcm_psen    (dcm_psen),
    .dcm_psincdec(dcm_psincdec),
    .dcm_psdone  (dcm_psdone),
    .ready       (ready),
    .phase       (phase),
    .lock_err    (lock_err),
    .ps_err      (ps_err)
  );

  always #5 m_clock = ~m_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge m_clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk(name, int'(ready), 1);
  endtask

  task automatic wait_rst(input string name, input bit val);
    int n = 0;
    while (dcm_rst !== val && n < 50) begin
      tick();
      n++;
    end
    chk(name, int'(dcm_rst), int'(val));
  endtask

  // One-cycle step request; PSDONE is answered 5 cycles after PSEN.
  task automatic do_step(input bit inc, output int acks, output int rej, output int psens,
                         output int dir_bad, output int ph, output int rdy);
    int psen_at = -1;
    acks = 0; rej = 0; psens = 0; dir_bad = 0; ph = 0; rdy = 0;
    step_req = 1'b1;
    step_inc = inc;
    tick();
    step_req = 1'b0;
    for (int n = 0; n < 40; n++) begin
      dcm_psdone = 1'b0;
      if (dcm_psen) begin
        psens++;
        psen_at = n;
        if (dcm_psincdec !== inc) dir_bad++;
      end
      if (step_ack) begin
        acks++;
        rej = int'(step_rej);
        ph  = int'(phase);
        rdy = int'(ready);
        break;
      end
      if (psen_at >= 0 && n == psen_at + 5) dcm_psdone = 1'b1;
      tick();
    end
    dcm_psdone = 1'b0;
    tick();
  endtask

  initial begin
    int acks, rej, psens, dir_bad, ph, rdy, hi, n;

    vecs[0] = '{1'b0, 1'b1,  1, 1'b0};
    vecs[1] = '{1'b0, 1'b1,  2, 1'b0};
    vecs[2] = '{1'b0, 1'b1,  2, 1'b1};
    vecs[3] = '{1'b1, 1'b0, -1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, -2, 1'b0};
    vecs[5] = '{1'b0, 1'b0, -2, 1'b1};
    vecs[6] = '{1'b0, 1'b0, -2, 1'b1};
    vecs[7] = '{1'b0, 1'b0, -2, 1'b1};

    p_reset = 1'b1; relock = 1'b0; step_req = 1'b0; step_inc = 1'b0;
    dcm_locked = 1'b0; dcm_status = 8'h00; dcm_psdone = 1'b0;
    repeat (3) tick();
    chk("rst_dcm_rst", int'(dcm_rst), 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_psen", int'(dcm_psen), 0);
    chk("rst_ack", int'(step_ack), 0);
    chk("rst_errs", int'({lock_err, ps_err}), 0);
    chk("rst_phase", int'(phase), 0);

    // Bring-up: dcm_rst high exactly 3 cycles, lock at +20, ready 3 cycles later.
    p_reset = 1'b0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (dcm_rst) hi++;
      tick();
    end
    chk("bringup_rst_cycles", hi, 3);
    repeat (10) tick();
    dcm_locked = 1'b1;
    tick(); tick();
    chk("bringup_ready_early", int'(ready), 0);
    tick();
    chk("bringup_ready", int'(ready), 1);
    chk("bringup_phase", int'(phase), 0);
    chk("bringup_errs", int'({lock_err, ps_err}), 0);
    $display("bringup: ready=%0b phase=%0d", ready, phase);

    // Step vectors: increments to +2, relock, decrements to -2 with rejects.
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].pre_relock) begin
        relock = 1'b1;
        tick();
        relock = 1'b0;
        chk("relock_rst", int'(dcm_rst), 1);
        chk("relock_phase", int'(phase), 0);
        wait_ready("relock_ready");
      end
      do_step(vecs[v].inc, acks, rej, psens, dir_bad, ph, rdy);
      $display("step %0d: inc=%0b ack=%0d rej=%0d psen=%0d phase=%0d", v, vecs[v].inc, acks, rej, psens, ph);
      chk("step_ack", acks, 1);
      chk("step_rej", rej, int'(vecs[v].exp_rej));
      chk("step_phase", ph, vecs[v].exp_phase);
      chk("step_psen_count", psens, vecs[v].exp_rej ? 0 : 1);
      chk("step_psincdec", dir_bad, 0);
      chk("step_ready", rdy, 1);
    end

    // Held request at the limit: one reject per ack, ack cycle blanks the next sample.
    step_req = 1'b1; step_inc = 1'b0;
    acks = 0; psens = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (step_ack && step_rej) acks++;
      if (dcm_psen) psens++;
    end
    step_req = 1'b0;
    tick();
    chk("held_rejects", acks, 3);
    chk("held_psen", psens, 0);
    $display("held: rejects=%0d psen=%0d", acks, psens);

    // Lock timeout: lock_err after 100 WAIT_LOCK cycles, then 3-cycle re-pulse.
    dcm_locked = 1'b0;
    wait_rst("lockto_rst_rise", 1'b1);
    wait_rst("lockto_rst_fall", 1'b0);
    n = 0;
    while (!lock_err && n < 300) begin
      tick();
      n++;
    end
    chk("lockto_cycles", n, 100);
    chk("lockto_rst", int'(dcm_rst), 1);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (dcm_rst) hi++;
      tick();
    end
    chk("lockto_repulse", hi, 3);
    dcm_locked = 1'b1;
    wait_ready("lockto_ready");
    chk("lockto_sticky", int'(lock_err), 1);
    chk("lockto_ps_err", int'(ps_err), 0);
    $display("lock timeout: cycles=%0d lock_err=%0b", n, lock_err);

    // PSDONE timeout: ps_err, no ack, reset re-pulse.
    step_req = 1'b1; step_inc = 1'b1;
    tick();
    step_req = 1'b0;
    chk("psto_psen", int'(dcm_psen), 1);
    n = 0; acks = 0;
    while (!ps_err && n < 300) begin
      tick();
      n++;
      if (step_ack) acks++;
    end
    chk("psto_cycles", n, 101);
    chk("psto_no_ack", acks, 0);
    chk("psto_rst", int'(dcm_rst), 1);
    chk("psto_phase", int'(phase), 0);
    wait_ready("psto_ready");
    chk("psto_sticky", int'(ps_err), 1);
    $display("ps timeout: cycles=%0d ps_err=%0b", n, ps_err);

    // Lock loss in PS_WAIT coinciding with PSDONE: no ack, phase cleared.
    do_step(1'b1, acks, rej, psens, dir_bad, ph, rdy);
    chk("loss_pre_phase", ph, 1);
    step_req = 1'b1; step_inc = 1'b1;
    tick();
    step_req = 1'b0;
    chk("loss_psen", int'(dcm_psen), 1);
    tick();
    dcm_locked = 1'b0;
    tick(); tick();
    dcm_psdone = 1'b1;
    tick();
    dcm_psdone = 1'b0;
    chk("loss_rst", int'(dcm_rst), 1);
    chk("loss_phase", int'(phase), 0);
    acks = int'(step_ack);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (step_ack) acks++;
    end
    chk("loss_no_ack", acks, 0);
    dcm_locked = 1'b1;
    wait_ready("loss_ready");
    $display("lock loss: phase=%0d acks=%0d", phase, acks);

    // Status: only bit 1 forces recovery.
    do_step(1'b1, acks, rej, psens, dir_bad, ph, rdy);
    chk("status_pre_phase", ph, 1);
    dcm_status = 8'hFD;
    repeat (3) tick();
    chk("status_other_bits", int'(ready), 1);
    dcm_status = 8'h02;
    tick();
    dcm_status = 8'h00;
    chk("status_rst", int'(dcm_rst), 1);
    chk("status_ready", int'(ready), 0);
    chk("status_phase", int'(phase), 0);
    wait_ready("status_recover");
    $display("status stop: recovered ready=%0b", ready);

    // relock during WAIT_LOCK is ignored.
    dcm_locked = 1'b0;
    wait_rst("wl_rst_rise", 1'b1);
    wait_rst("wl_rst_fall", 1'b0);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (dcm_rst) hi++;
      tick();
    end
    chk("wl_relock_ignored", hi, 0);
    dcm_locked = 1'b1;
    wait_ready("wl_ready");
    $display("relock in wait_lock: rst_cycles=%0d", hi);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
